// File: rtl/tron_video_pkg.sv
// Shared video definitions for the frame-buffer reader and writer paths.
// Used by sram_frame_writer (optional drop counter: SRAM_FRAME_WRITER_DROPCNT_EN).
package tron_video_pkg;

    localparam int          H_RES       = 640;
    localparam int          V_RES       = 480;
    localparam int          FRAME_WORDS = H_RES * V_RES;
    localparam logic [19:0] FRAME0_BASE = 20'h00000;
    localparam logic [19:0] FRAME1_BASE = 20'h4B000;
    localparam int          WR_CYCLES   = 2;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_CLR_NEXT = 3'd4
    } writer_state_e;

endpackage

// File: rtl/sram_addr_gen.sv
// Pixel (x, y, frame) to SRAM word address; line stride is fixed at 640 words.
// Shared with the reader path.
module sram_addr_gen #(
    parameter int          H_RES       = tron_video_pkg::H_RES,
    parameter int          V_RES       = tron_video_pkg::V_RES,
    parameter logic [19:0] FRAME1_BASE = tron_video_pkg::FRAME1_BASE
) (
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic        frame_sel,
    output logic [19:0] addr,
    output logic        in_range
);

    logic [19:0] y_ext;
    logic [19:0] base;

    always_comb begin
        y_ext    = {11'd0, pix_y};
        base     = frame_sel ? FRAME1_BASE : tron_video_pkg::FRAME0_BASE;
        // y*640 as two shifts keeps this a pair of adders rather than a multiplier
        addr     = base + (y_ext << 9) + (y_ext << 7) + {10'd0, pix_x};
        in_range = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
    end

endmodule

// File: rtl/sram_frame_writer.sv
// Turns pixel draws and whole-frame clears into async-SRAM write cycles.
// Optional drop counter output enabled by SRAM_FRAME_WRITER_DROPCNT_EN.
module sram_frame_writer import tron_video_pkg::*; #(
    parameter int          H_RES       = tron_video_pkg::H_RES,
    parameter int          V_RES       = tron_video_pkg::V_RES,
    parameter logic [19:0] FRAME1_BASE = tron_video_pkg::FRAME1_BASE,
    parameter int          WR_CYCLES   = tron_video_pkg::WR_CYCLES
) (
    input  logic          Clk,
    input  logic          Reset,
    // pix_valid/pix_ready: a pixel transfers on a rising edge where both are high;
    // the request must stay stable while pix_valid is high and pix_ready is low.
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic [9:0]    pix_x,
    input  logic [8:0]    pix_y,
    input  rgb565_t       pix_color,
    input  logic          frame_sel,
    input  logic          clear_start,
    input  rgb565_t       clear_color,
    output logic          busy,
    output logic          clear_done,
    output logic          CE,
    output logic          UB,
    output logic          LB,
    output logic          OE,
    output logic          WE,
    output logic [19:0]   ADDR,
    output rgb565_t       Data_to_SRAM,
    output logic          Data_oe,
`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
    output logic [15:0]   drop_count,
`endif
    output writer_state_e state_dbg
);

    localparam logic [3:0]  WR_LAST  = 4'(WR_CYCLES - 1);
    localparam logic [19:0] CLR_SPAN = 20'(H_RES * V_RES - 1);

    writer_state_e state, state_n;
    logic [3:0]    wr_cnt, wr_cnt_n;
    logic          clr_mode, clr_mode_n;
    logic [19:0]   clr_last, clr_last_n;
    logic [19:0]   addr_n;
    rgb565_t       data_n;
    logic          done_n;
    logic          cyc_n;
    logic          idle_clear, pix_take;
    logic [19:0]   gen_addr, clr_base;
    logic          gen_in_range;

    sram_addr_gen #(
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .FRAME1_BASE (FRAME1_BASE)
    ) u_addr_gen (
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_sel (frame_sel),
        .addr      (gen_addr),
        .in_range  (gen_in_range)
    );

    // Clear wins over a simultaneous pixel; the pixel simply stays pending.
    assign idle_clear = (state == ST_IDLE) && clear_start;
    assign pix_take   = (state == ST_IDLE) && !clear_start && pix_valid && pix_ready;
    assign clr_base   = frame_sel ? FRAME1_BASE : FRAME0_BASE;
    assign state_dbg  = state;

    always_comb begin
        state_n    = state;
        wr_cnt_n   = wr_cnt;
        clr_mode_n = clr_mode;
        clr_last_n = clr_last;
        addr_n     = ADDR;
        data_n     = Data_to_SRAM;
        done_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (idle_clear) begin
                    state_n    = ST_SETUP;
                    clr_mode_n = 1'b1;
                    addr_n     = clr_base;
                    clr_last_n = clr_base + CLR_SPAN;
                    data_n     = clear_color;
                end else if (pix_take && gen_in_range) begin
                    state_n    = ST_SETUP;
                    clr_mode_n = 1'b0;
                    addr_n     = gen_addr;
                    data_n     = pix_color;
                end
            end
            ST_SETUP: begin
                state_n  = ST_WRITE;
                wr_cnt_n = 4'd0;
            end
            ST_WRITE: begin
                if (wr_cnt == WR_LAST) state_n = ST_HOLD;
                else                   wr_cnt_n = wr_cnt + 4'd1;
            end
            ST_HOLD: begin
                state_n = clr_mode ? ST_CLR_NEXT : ST_IDLE;
            end
            ST_CLR_NEXT: begin
                if (ADDR == clr_last) begin
                    state_n    = ST_IDLE;
                    clr_mode_n = 1'b0;
                    done_n     = 1'b1;
                end else begin
                    state_n = ST_SETUP;
                    addr_n  = ADDR + 20'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    assign cyc_n = (state_n == ST_SETUP) || (state_n == ST_WRITE) || (state_n == ST_HOLD);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            wr_cnt       <= 4'd0;
            clr_mode     <= 1'b0;
            clr_last     <= 20'd0;
            ADDR         <= 20'd0;
            Data_to_SRAM <= 16'd0;
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            Data_oe      <= 1'b0;
            pix_ready    <= 1'b0;
            busy         <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            state        <= state_n;
            wr_cnt       <= wr_cnt_n;
            clr_mode     <= clr_mode_n;
            clr_last     <= clr_last_n;
            ADDR         <= addr_n;
            Data_to_SRAM <= data_n;
            CE           <= !cyc_n;
            UB           <= !cyc_n;
            LB           <= !cyc_n;
            OE           <= 1'b1;
            WE           <= (state_n != ST_WRITE);
            Data_oe      <= cyc_n;
            pix_ready    <= (state_n == ST_IDLE);
            busy         <= (state_n != ST_IDLE);
            clear_done   <= done_n;
        end
    end

`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            drop_count <= 16'd0;
        end else if (idle_clear) begin
            drop_count <= 16'd0;
        end else if (pix_take && !gen_in_range && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer: a full-size instance for pixel paths and a
// two-line instance (WR_CYCLES=1) so a complete clear fits in a short run.
module tb_sram_frame_writer;
    import tron_video_pkg::*;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic [15:0]   pix_color, clear_color;

    logic          pix_valid, frame_sel, clear_start;
    logic          pix_ready, busy, clear_done, ce, ub, lb, oe, we, data_oe;
    logic [19:0]   addr;
    logic [15:0]   data;
    writer_state_e state;

    logic          s_pix_valid, s_frame_sel, s_clear_start;
    logic          s_pix_ready, s_busy, s_clear_done, s_ce, s_ub, s_lb, s_oe, s_we, s_data_oe;
    logic [19:0]   s_addr;
    logic [15:0]   s_data;
    writer_state_e s_state;
`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
    logic [15:0]   drop_count, s_drop_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    sram_frame_writer dut (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_sel(frame_sel), .clear_start(clear_start), .clear_color(clear_color),
        .busy(busy), .clear_done(clear_done),
        .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
        .ADDR(addr), .Data_to_SRAM(data), .Data_oe(data_oe),
`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
        .drop_count(drop_count),
`endif
        .state_dbg(state)
    );

    sram_frame_writer #(.V_RES(2), .WR_CYCLES(1)) dut_s (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_sel(s_frame_sel), .clear_start(s_clear_start), .clear_color(clear_color),
        .busy(s_busy), .clear_done(s_clear_done),
        .CE(s_ce), .UB(s_ub), .LB(s_lb), .OE(s_oe), .WE(s_we),
        .ADDR(s_addr), .Data_to_SRAM(s_data), .Data_oe(s_data_oe),
`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
        .drop_count(s_drop_count),
`endif
        .state_dbg(s_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One in-range pixel on the full-size instance, checked cycle by cycle.
    task automatic do_pixel(input string tag, input logic [9:0] x, input logic [8:0] y,
                            input logic f, input logic [15:0] c, input logic [19:0] exp_addr);
        int we_low;
        pix_x = x; pix_y = y; frame_sel = f; pix_color = c; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; frame_sel = ~f; pix_color = ~c;
        check({tag, "_setup"}, {state, ce, we, data_oe, busy, pix_ready},
              {ST_SETUP, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        check({tag, "_addr"}, addr, exp_addr);
        check({tag, "_data"}, data, c);
        we_low = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (we === 1'b0) we_low++;
            if (i < 3)
                check({tag, "_drive"}, {ub, lb, ce, data_oe, addr, data},
                      {1'b0, 1'b0, 1'b0, 1'b1, exp_addr, c});
            if (i == 2)
                check({tag, "_hold"}, {state, we}, {ST_HOLD, 1'b1});
        end
        check({tag, "_we_low"}, we_low, 2);
        check({tag, "_idle"}, {state, ce, we, oe, data_oe, busy, pix_ready},
              {ST_IDLE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int          writes, errs, stray;
        logic [19:0] exp_a;

        Reset = 1'b0;
        pix_valid = 1'b0; frame_sel = 1'b0; clear_start = 1'b0;
        s_pix_valid = 1'b0; s_frame_sel = 1'b0; s_clear_start = 1'b0;
        pix_x = '0; pix_y = '0; pix_color = '0; clear_color = '0;

        repeat (3) tick();
        check("rst_ctl", {ce, ub, lb, oe, we, data_oe}, 6'b111110);
        check("rst_addr", addr, 20'd0);
        check("rst_data", data, 16'd0);
        check("rst_hs", {pix_ready, busy, clear_done}, 3'b000);
        check("rst_state", state, ST_IDLE);

        Reset = 1'b1;
        check("rel_ready0", pix_ready, 1'b0);
        tick();
        check("rel_ready1", {pix_ready, busy}, 2'b10);

        do_pixel("px_3_2", 10'd3, 9'd2, 1'b0, 16'h07E0, 20'd1283);
        do_pixel("px_max_f1", 10'd639, 9'd479, 1'b1, 16'hF800, 20'h95FFF);
        do_pixel("px_org_f1", 10'd0, 9'd0, 1'b1, 16'h001F, 20'h4B000);

        // Out-of-range requests are consumed with no SRAM activity.
        pix_x = 10'd640; pix_y = 9'd0; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        check("oor_x", {state, ce, we, data_oe, busy, pix_ready},
              {ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        check("oor_x_after", {state, ce, we}, {ST_IDLE, 1'b1, 1'b1});
        pix_x = 10'd0; pix_y = 9'd480; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        check("oor_y", {state, ce, we, data_oe, busy, pix_ready},
              {ST_IDLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
`ifdef SRAM_FRAME_WRITER_DROPCNT_EN
        check("drop_count", drop_count, 16'd2);
`endif

        // clear_start while a pixel write is in flight must be ignored.
        pix_x = 10'd10; pix_y = 9'd1; frame_sel = 1'b0; pix_color = 16'h1234; pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("busy_clr_addr", {state, addr}, {ST_WRITE, 20'h0028A});
        repeat (3) tick();
        check("busy_clr_idle", {state, ce, busy, clear_done}, {ST_IDLE, 1'b1, 1'b0, 1'b0});
        tick();
        check("busy_clr_stays", {state, ce}, {ST_IDLE, 1'b1});

        // Reset in the middle of a clear write drops the cycle immediately.
        frame_sel = 1'b0; clear_color = 16'h5555; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        check("clr0_setup", {state, addr, data}, {ST_SETUP, 20'd0, 16'h5555});
        tick();
        check("clr0_write", {state, we, ce}, {ST_WRITE, 1'b0, 1'b0});
        #2;
        Reset = 1'b0;
        #1;
        check("abort_ctl", {we, ce, data_oe, busy, pix_ready, state},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE});
        tick();
        Reset = 1'b1;
        check("abort_ready0", pix_ready, 1'b0);
        tick();
        check("abort_ready1", {pix_ready, state}, {1'b1, ST_IDLE});
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ce !== 1'b1 || we !== 1'b1 || busy !== 1'b0) stray++;
        end
        check("abort_no_resume", stray, 0);

        // Full clear of frame 1 on the two-line instance with a pixel waiting alongside.
        clear_color = 16'hF81F; s_frame_sel = 1'b1; s_clear_start = 1'b1;
        pix_x = 10'd5; pix_y = 9'd1; pix_color = 16'h1357; s_pix_valid = 1'b1;
        tick();
        s_clear_start = 1'b0; s_frame_sel = 1'b0; clear_color = 16'h0000;
        check("sclr_start", {s_state, s_pix_ready, s_addr}, {ST_SETUP, 1'b0, 20'h4B000});
        exp_a = 20'h4B000; writes = 0; errs = 0;
        for (int cyc = 0; cyc < 8000 && s_clear_done !== 1'b1; cyc++) begin
            if (s_we === 1'b0) begin
                if (s_addr !== exp_a || s_data !== 16'hF81F || s_ce !== 1'b0 || s_data_oe !== 1'b1)
                    errs++;
                exp_a = exp_a + 20'd1;
                writes++;
            end
            if (s_pix_ready !== 1'b0 || s_busy !== 1'b1) errs++;
            if (s_clear_start === 1'b0 && cyc == 20) s_clear_start = 1'b1;
            else s_clear_start = 1'b0;
            tick();
        end
        check("sclr_done_seen", s_clear_done, 1'b1);
        check("sclr_writes", writes, 1280);
        check("sclr_seq_errs", errs, 0);
        check("sclr_last_addr", exp_a, 20'h4B500);
        check("sclr_end_state", {s_state, s_busy, s_ce, s_data_oe, s_pix_ready},
              {ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b1});
        tick();
        s_pix_valid = 1'b0;
        check("sclr_done_pulse", s_clear_done, 1'b0);
        check("spx_accept", {s_state, s_addr, s_data}, {ST_SETUP, 20'h00285, 16'h1357});
        repeat (3) tick();
        check("spx_idle", {s_state, s_clear_done, s_ce, s_busy}, {ST_IDLE, 1'b0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
